// File: rtl/seq_matrix_multiplication.sv
// ---------------------------------------------------------------------------
// seq_matrix_multiplication
//
// Sequential signed fixed-point matrix multiplier, C = A x B, for N x N
// matrices. N multiply-accumulate lanes each own one output column. Every
// cycle they consume one A element and one B row. Each output row therefore
// takes N cycles, and a full job takes N*N cycles. Results are rounded
// (optional half-up), shifted down by FRAC and saturated to W bits.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   enable     stalls COMPUTE progress when low (does not gate acceptance)
//   in_valid   operand pair valid
//   in_ready   block idle and able to accept operands
//   in_a/in_b  row-major operands, element (r,c) at [W*(r*N+c) +: W]
//   out_valid  out_c holds a complete result
//   out_ready  consumer accepts the result
//   out_c      row-major result, same layout as the operands
//   out_sat    at least one element of out_c was clamped
//   busy       a job is in progress or awaiting hand-off
// ---------------------------------------------------------------------------
module seq_matrix_multiplication #(
  parameter int N     = 4,
  parameter int W     = 16,
  parameter int FRAC  = 10,
  parameter int ROUND = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*N*W-1:0] in_a,
  input  logic [N*N*W-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*N*W-1:0] out_c,
  output logic             out_sat,
  output logic             busy
);

  localparam int KW    = $clog2(N);
  localparam int ACC_W = 2 * W + $clog2(N);
  localparam int MW    = N * N * W;

  // Rounding constant and clamp limits, held one bit wider than the
  // accumulator so the half-up addition can never wrap.
  localparam logic signed [ACC_W:0] HALF  =
      (ROUND != 0) ? ((ACC_W + 1)'(1) << (FRAC - 1)) : '0;
  localparam logic signed [ACC_W:0] MAX_V =
      {{(ACC_W - W + 2){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] MIN_V =
      {{(ACC_W - W + 2){1'b1}}, {(W - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_e;

  state_e                   state_q, state_d;
  logic [KW-1:0]            k_q, k_d;
  logic [KW-1:0]            row_q, row_d;
  logic signed [ACC_W-1:0]  acc_q [N];
  logic signed [ACC_W-1:0]  acc_d [N];
  logic [MW-1:0]            out_c_q, out_c_d;
  logic                     out_sat_q, out_sat_d;
  logic                     out_valid_q, out_valid_d;
  logic [MW-1:0]            a_q, b_q;

  logic signed [2*W-1:0]    prod [N];
  logic signed [ACC_W-1:0]  sum  [N];
  logic [W:0]               rs   [N];  // {saturated, value}
  logic                     accept;

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_c     = out_c_q;
  assign out_sat   = out_sat_q;

  // Round (optional), arithmetic shift, then clamp to the signed W-bit range.
  function automatic logic [W:0] round_sat(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W:0] r;
    r = (ACC_W + 1)'(v) + HALF;
    r = r >>> FRAC;
    if (r > MAX_V) return {1'b1, 1'b0, {(W - 1){1'b1}}};
    if (r < MIN_V) return {1'b1, 1'b1, {(W - 1){1'b0}}};
    return {1'b0, r[W-1:0]};
  endfunction

  // Lane j: acc[j] + A[row][k] * B[k][j], plus its rounded/saturated form
  // for the row-closing step.
  always_comb begin : mac_datapath
    for (int j = 0; j < N; j++) begin
      prod[j] = $signed(a_q[W*(int'(row_q)*N + int'(k_q)) +: W])
              * $signed(b_q[W*(int'(k_q)*N + j) +: W]);
      sum[j]  = acc_q[j] + ACC_W'(prod[j]);
      rs[j]   = round_sat(sum[j]);
    end
  end

  always_comb begin : next_state
    // NOTE: every variable gets its hold value first so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    k_d         = k_q;
    row_d       = row_q;
    acc_d       = acc_q;
    out_c_d     = out_c_q;
    out_sat_d   = out_sat_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d   = COMPUTE;
          k_d       = '0;
          row_d     = '0;
          out_sat_d = 1'b0;
          for (int j = 0; j < N; j++) acc_d[j] = '0;
        end
      end
      COMPUTE: begin
        if (enable) begin
          if (k_q == KW'(N - 1)) begin
            // Row closes: publish it and restart the lanes for the next row.
            for (int j = 0; j < N; j++) begin
              out_c_d[W*(int'(row_q)*N + j) +: W] = rs[j][W-1:0];
              if (rs[j][W]) out_sat_d = 1'b1;
              acc_d[j] = '0;
            end
            k_d = '0;
            if (row_q == KW'(N - 1)) begin
              row_d       = '0;
              state_d     = DONE;
              out_valid_d = 1'b1;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            for (int j = 0; j < N; j++) acc_d[j] = sum[j];
            k_d = k_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      row_q       <= '0;
      acc_q       <= '{default: '0};
      out_c_q     <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      row_q       <= row_d;
      acc_q       <= acc_d;
      out_c_q     <= out_c_d;
      out_sat_q   <= out_sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  // NOTE: operand registers carry no reset; they are only read in COMPUTE,
  // which is reachable solely through an accept that loads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= in_a;
      b_q <= in_b;
    end
  end

endmodule

// File: tb/tb_seq_matrix_multiplication.sv
// ---------------------------------------------------------------------------
// tb_seq_matrix_multiplication
//
// Directed bench for seq_matrix_multiplication (N=4, W=16, FRAC=10). Two
// instances share all inputs: dut rounds half-up, dut_t truncates.
// ---------------------------------------------------------------------------
module tb_seq_matrix_multiplication;

  localparam int N    = 4;
  localparam int W    = 16;
  localparam int FRAC = 10;
  localparam int MW   = N * N * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          in_valid;
  logic          out_ready;
  logic [MW-1:0] in_a, in_b;

  logic          in_ready, out_valid, out_sat, busy;
  logic [MW-1:0] out_c;
  logic          in_ready_t, out_valid_t, out_sat_t, busy_t;
  logic [MW-1:0] out_c_t;

  int vectors     = 0;
  int miscompares = 0;
  int cycle       = 0;
  int t0          = 0;
  int lat;

  seq_matrix_multiplication #(.N(N), .W(W), .FRAC(FRAC), .ROUND(1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c),
    .out_sat(out_sat), .busy(busy)
  );

  seq_matrix_multiplication #(.N(N), .W(W), .FRAC(FRAC), .ROUND(0)) dut_t (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready_t), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid_t), .out_ready(out_ready), .out_c(out_c_t),
    .out_sat(out_sat_t), .busy(busy_t)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [MW-1:0] obs,
                       input logic [MW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [MW-1:0] fill(input logic [W-1:0] v);
    logic [MW-1:0] m;
    for (int i = 0; i < N*N; i++) m[W*i +: W] = v;
    return m;
  endfunction

  function automatic logic [MW-1:0] ident();
    logic [MW-1:0] m;
    m = '0;
    for (int r = 0; r < N; r++) m[W*(r*N + r) +: W] = 16'h0400;
    return m;
  endfunction

  // Mixed-sign values well inside range, so identity must reproduce them.
  function automatic logic [MW-1:0] ramp();
    logic [MW-1:0] m;
    for (int i = 0; i < N*N; i++) m[W*i +: W] = W'(i * 273 - 2000);
    return m;
  endfunction

  function automatic logic [MW-1:0] single(input logic [W-1:0] v);
    logic [MW-1:0] m;
    m = '0;
    m[W-1:0] = v;
    return m;
  endfunction

  // Present operands for one edge; t0 is the accept edge.
  task automatic start_job(input logic [MW-1:0] a, input logic [MW-1:0] b);
    @(negedge clk);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    t0       = cycle;
    in_valid = 1'b0;
  endtask

  // Cycles from accept edge to out_valid, bounded at 200.
  task automatic wait_done(output int l);
    while (!out_valid && (cycle - t0) < 200) begin
      @(posedge clk);
      #1;
    end
    l = cycle - t0;
  endtask

  task automatic finish_job();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("idle_after_ready", in_ready, 1'b1);
    check("valid_drop", out_valid, 1'b0);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_c", out_c, '0);
    check("rst_out_sat", out_sat, 1'b0);
    check("rst_busy", {busy, busy_t}, 2'b00);
    check("rst_in_ready", {in_ready, in_ready_t}, 2'b11);
    rst_n = 1'b1;

    // Identity: C == B, 16-cycle latency, held in DONE
    start_job(ident(), ramp());
    check("ident_busy", busy, 1'b1);
    wait_done(lat);
    check("ident_latency", lat, 16);
    check("ident_c", out_c, ramp());
    check("ident_sat", out_sat, 1'b0);
    check("done_in_ready", in_ready, 1'b0);
    finish_job();

    // Constant fill: 4 * 2.0 * 3.0 = 24.0
    start_job(fill(16'h0800), fill(16'h0C00));
    wait_done(lat);
    check("const_c", out_c, fill(16'h6000));
    check("const_sat", out_sat, 1'b0);
    finish_job();

    // Positive saturation
    start_job(fill(16'h7FFF), fill(16'h7FFF));
    wait_done(lat);
    check("satpos_c", out_c, fill(16'h7FFF));
    check("satpos_sat", {out_sat, out_sat_t}, 2'b11);
    finish_job();

    // Negative saturation
    start_job(fill(16'h8000), fill(16'h7FFF));
    wait_done(lat);
    check("satneg_c", out_c, fill(16'h8000));
    check("satneg_sat", out_sat, 1'b1);
    finish_job();

    // In-range accept clears the sticky flag
    start_job(fill(16'h0800), fill(16'h0C00));
    check("sat_clear_on_accept", out_sat, 1'b0);
    wait_done(lat);
    check("sat_clear_c", out_c, fill(16'h6000));
    check("sat_clear_done", out_sat, 1'b0);
    finish_job();

    // Rounding: +0.5 LSB
    start_job(single(16'h0001), single(16'h0200));
    wait_done(lat);
    check("round_pos_r1", out_c, single(16'h0001));
    check("round_pos_r0", out_c_t, '0);
    finish_job();

    // Rounding: -0.5 LSB
    start_job(single(16'hFFFF), single(16'h0200));
    wait_done(lat);
    check("round_neg_r1", out_c, '0);
    check("round_neg_r0", out_c_t, single(16'hFFFF));
    finish_job();

    // Five enable-low cycles mid-COMPUTE add five cycles
    start_job(ident(), ramp());
    repeat (2) @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    enable = 1'b1;
    wait_done(lat);
    check("stall_latency", lat, 21);
    check("stall_c", out_c, ramp());

    // Consumer back-pressure with a competing in_valid
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_a     = fill(16'h0400);
      in_b     = fill(16'h0400);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("bp_c_stable", out_c, ramp());
      check("bp_hold", {out_valid, in_ready}, 2'b10);
    end
    @(negedge clk);
    in_valid = 1'b0;
    finish_job();
    check("bp_no_accept", busy, 1'b0);

    // Reset mid-job aborts
    start_job(ident(), ramp());
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_valid", out_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Identity job after abort
    start_job(ident(), fill(16'hFC00));
    wait_done(lat);
    check("post_abort_latency", lat, 16);
    check("post_abort_c", out_c, fill(16'hFC00));
    check("post_abort_sat", out_sat, 1'b0);
    finish_job();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
